// File: rtl/coef_load_sequencer.sv
// coef_load_sequencer
// Turns single-cycle SPI write strobes into addressed FIR coefficient and EQ
// gain RAM writes with auto-incrementing addresses. FIR coefficients are
// double-buffered: writes go to the shadow bank (~active_bank), and a commit
// request swaps banks on the first frame_stb seen while the FIR MAC is idle.
//
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   coef_wr_stb         one-cycle FIR coefficient write strobe
//   eq_wr_stb           one-cycle EQ gain write strobe
//   filter_select       [1:0] filter, [6] commit (rising edge), [7] restart (rising edge)
//   taps_per_filter     taps per filter minus 1
//   coef_lsb/coef_msb   coefficient data bytes
//   eq_lsb/eq_msb       EQ gain data bytes
//   frame_stb           stereo frame start pulse
//   fir_busy            FIR MAC is reading coefficients
//   coef_we/coef_bank/coef_filter/coef_addr/coef_wdata  coefficient RAM write port
//   active_bank         bank read by the FIR datapath
//   eq_we/eq_addr/eq_wdata  EQ RAM write port
//   load_busy           commit pending
//   status              [0] commit done, [1] overflow, [2] write while pending (all sticky)
module coef_load_sequencer #(
  parameter int unsigned NUM_FILTERS = 4,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned COEF_W      = 16,
  parameter int unsigned NUM_EQ      = 8,
  localparam int unsigned FiltW      = $clog2(NUM_FILTERS),
  localparam int unsigned EqW        = $clog2(NUM_EQ)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              coef_wr_stb,
  input  logic              eq_wr_stb,
  input  logic [7:0]        filter_select,
  input  logic [7:0]        taps_per_filter,
  input  logic [7:0]        coef_lsb,
  input  logic [7:0]        coef_msb,
  input  logic [7:0]        eq_lsb,
  input  logic [7:0]        eq_msb,
  input  logic              frame_stb,
  input  logic              fir_busy,
  output logic              coef_we,
  output logic              coef_bank,
  output logic [FiltW-1:0]  coef_filter,
  output logic [ADDR_W-1:0] coef_addr,
  output logic [COEF_W-1:0] coef_wdata,
  output logic              active_bank,
  output logic              eq_we,
  output logic [EqW-1:0]    eq_addr,
  output logic [COEF_W-1:0] eq_wdata,
  output logic              load_busy,
  output logic [7:0]        status
);

  // One extra bit so a counter that ran past taps_per_filter = 255 is still
  // detectable as an overflow instead of wrapping back to 0.
  localparam int unsigned CntW = ADDR_W + 1;

  typedef enum logic [0:0] {StIdle, StPendSwap} state_e;

  state_e             state_q, state_d;
  logic               active_bank_q, active_bank_d;
  logic [CntW-1:0]    coef_cnt_q, coef_cnt_d;
  logic [EqW-1:0]     eq_cnt_q, eq_cnt_d;
  logic [FiltW-1:0]   filt_prev_q, filt_prev_d;
  logic               commit_prev_q, commit_prev_d;
  logic               restart_prev_q, restart_prev_d;
  logic               coef_we_q, coef_we_d;
  logic [FiltW-1:0]   coef_filter_q, coef_filter_d;
  logic [ADDR_W-1:0]  coef_addr_q, coef_addr_d;
  logic [COEF_W-1:0]  coef_wdata_q, coef_wdata_d;
  logic               eq_we_q, eq_we_d;
  logic [EqW-1:0]     eq_addr_q, eq_addr_d;
  logic [COEF_W-1:0]  eq_wdata_q, eq_wdata_d;
  logic [2:0]         status_q, status_d;

  logic               restart_edge, commit_edge, filt_change;
  logic [CntW-1:0]    coef_cnt_eff;
  logic [EqW-1:0]     eq_cnt_eff;
  logic [CntW-1:0]    taps_ext;
  logic               unused_fsel;

  assign unused_fsel = ^filter_select[5:FiltW];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      active_bank_q  <= 1'b0;
      coef_cnt_q     <= '0;
      eq_cnt_q       <= '0;
      filt_prev_q    <= '0;
      commit_prev_q  <= 1'b0;
      restart_prev_q <= 1'b0;
      coef_we_q      <= 1'b0;
      coef_filter_q  <= '0;
      coef_addr_q    <= '0;
      coef_wdata_q   <= '0;
      eq_we_q        <= 1'b0;
      eq_addr_q      <= '0;
      eq_wdata_q     <= '0;
      status_q       <= '0;
    end else begin
      state_q        <= state_d;
      active_bank_q  <= active_bank_d;
      coef_cnt_q     <= coef_cnt_d;
      eq_cnt_q       <= eq_cnt_d;
      filt_prev_q    <= filt_prev_d;
      commit_prev_q  <= commit_prev_d;
      restart_prev_q <= restart_prev_d;
      coef_we_q      <= coef_we_d;
      coef_filter_q  <= coef_filter_d;
      coef_addr_q    <= coef_addr_d;
      coef_wdata_q   <= coef_wdata_d;
      eq_we_q        <= eq_we_d;
      eq_addr_q      <= eq_addr_d;
      eq_wdata_q     <= eq_wdata_d;
      status_q       <= status_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    active_bank_d  = active_bank_q;
    coef_we_d      = 1'b0;
    coef_filter_d  = coef_filter_q;
    coef_addr_d    = coef_addr_q;
    coef_wdata_d   = coef_wdata_q;
    eq_we_d        = 1'b0;
    eq_addr_d      = eq_addr_q;
    eq_wdata_d     = eq_wdata_q;

    filt_prev_d    = filter_select[FiltW-1:0];
    commit_prev_d  = filter_select[6];
    restart_prev_d = filter_select[7];

    restart_edge   = filter_select[7] & ~restart_prev_q;
    commit_edge    = filter_select[6] & ~commit_prev_q;
    filt_change    = filter_select[FiltW-1:0] != filt_prev_q;
    taps_ext       = CntW'(taps_per_filter);

    // Restart and filter change take effect before a same-cycle strobe.
    coef_cnt_eff   = (restart_edge || filt_change) ? '0 : coef_cnt_q;
    eq_cnt_eff     = restart_edge ? '0 : eq_cnt_q;
    coef_cnt_d     = coef_cnt_eff;
    status_d       = restart_edge ? 3'b000 : status_q;

    unique case (state_q)
      StIdle: begin
        if (coef_wr_stb) begin
          if (coef_cnt_eff <= taps_ext) begin
            coef_we_d     = 1'b1;
            coef_filter_d = filter_select[FiltW-1:0];
            coef_addr_d   = coef_cnt_eff[ADDR_W-1:0];
            coef_wdata_d  = COEF_W'({coef_msb, coef_lsb});
            coef_cnt_d    = coef_cnt_eff + 1'b1;
          end else begin
            status_d[1] = 1'b1;
          end
        end
        if (commit_edge) begin
          state_d     = StPendSwap;
          status_d[0] = 1'b0;
        end
      end
      StPendSwap: begin
        // Shadow bank is frozen while a commit waits; further commits are ignored.
        if (coef_wr_stb) status_d[2] = 1'b1;
        if (frame_stb && !fir_busy) begin
          active_bank_d = ~active_bank_q;
          coef_cnt_d    = '0;
          status_d[0]   = 1'b1;
          state_d       = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    eq_cnt_d = eq_cnt_eff;
    if (eq_wr_stb) begin
      eq_we_d    = 1'b1;
      eq_addr_d  = eq_cnt_eff;
      eq_wdata_d = COEF_W'({eq_msb, eq_lsb});
      eq_cnt_d   = (eq_cnt_eff == EqW'(NUM_EQ - 1)) ? '0 : eq_cnt_eff + 1'b1;
    end
  end

  assign coef_we     = coef_we_q;
  assign coef_bank   = ~active_bank_q;
  assign coef_filter = coef_filter_q;
  assign coef_addr   = coef_addr_q;
  assign coef_wdata  = coef_wdata_q;
  assign active_bank = active_bank_q;
  assign eq_we       = eq_we_q;
  assign eq_addr     = eq_addr_q;
  assign eq_wdata    = eq_wdata_q;
  assign load_busy   = (state_q == StPendSwap);
  assign status      = {5'b00000, status_q};

endmodule

// File: tb/tb_coef_load_sequencer.sv
// Directed, table-driven bench for coef_load_sequencer. Each table row is one
// clock cycle: inputs applied before the edge, outputs checked 1 ns after it.
module tb_coef_load_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        coef_wr_stb, eq_wr_stb, frame_stb, fir_busy;
  logic [7:0]  filter_select, taps_per_filter;
  logic [7:0]  coef_lsb, coef_msb, eq_lsb, eq_msb;
  logic        coef_we, coef_bank, active_bank, eq_we, load_busy;
  logic [1:0]  coef_filter;
  logic [7:0]  coef_addr;
  logic [15:0] coef_wdata, eq_wdata;
  logic [2:0]  eq_addr;
  logic [7:0]  status;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  coef_load_sequencer dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .coef_wr_stb     (coef_wr_stb),
    .eq_wr_stb       (eq_wr_stb),
    .filter_select   (filter_select),
    .taps_per_filter (taps_per_filter),
    .coef_lsb        (coef_lsb),
    .coef_msb        (coef_msb),
    .eq_lsb          (eq_lsb),
    .eq_msb          (eq_msb),
    .frame_stb       (frame_stb),
    .fir_busy        (fir_busy),
    .coef_we         (coef_we),
    .coef_bank       (coef_bank),
    .coef_filter     (coef_filter),
    .coef_addr       (coef_addr),
    .coef_wdata      (coef_wdata),
    .active_bank     (active_bank),
    .eq_we           (eq_we),
    .eq_addr         (eq_addr),
    .eq_wdata        (eq_wdata),
    .load_busy       (load_busy),
    .status          (status)
  );

  typedef struct {
    logic        c, e;
    logic [7:0]  fsel, taps;
    logic        frm, bsy;
    logic [15:0] cd, ed;
    logic        we;
    logic [7:0]  addr;
    logic [1:0]  filt;
    logic [15:0] wd;
    logic        cb, ab, eqwe;
    logic [2:0]  eqa;
    logic [15:0] eqwd;
    logic        lb;
    logic [7:0]  st;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic c, logic e, logic [7:0] fsel, logic [7:0] taps,
                             logic frm, logic bsy, logic [15:0] cd, logic [15:0] ed,
                             logic we, logic [7:0] addr, logic [1:0] filt, logic [15:0] wd,
                             logic cb, logic ab, logic eqwe, logic [2:0] eqa,
                             logic [15:0] eqwd, logic lb, logic [7:0] st);
    vec_t r;
    r.c = c; r.e = e; r.fsel = fsel; r.taps = taps; r.frm = frm; r.bsy = bsy;
    r.cd = cd; r.ed = ed; r.we = we; r.addr = addr; r.filt = filt; r.wd = wd;
    r.cb = cb; r.ab = ab; r.eqwe = eqwe; r.eqa = eqa; r.eqwd = eqwd; r.lb = lb;
    r.st = st;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    coef_wr_stb = 1'b0; eq_wr_stb = 1'b0; frame_stb = 1'b0; fir_busy = 1'b0;
    coef_lsb = 8'h00; coef_msb = 8'h00; eq_lsb = 8'h00; eq_msb = 8'h00;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".coef_we"}, 32'(coef_we), 32'd0);
    chk({tag, ".eq_we"}, 32'(eq_we), 32'd0);
    chk({tag, ".active_bank"}, 32'(active_bank), 32'd0);
    chk({tag, ".coef_bank"}, 32'(coef_bank), 32'd1);
    chk({tag, ".load_busy"}, 32'(load_busy), 32'd0);
    chk({tag, ".status"}, 32'(status), 32'd0);
  endtask

  initial begin
    // Filter 2, taps 3: four writes, fifth overflows.
    vecs.push_back(v(0,0,8'h02,3,0,0,16'h0000,16'h0000, 0,0,0,16'h0000,1,0,0,0,16'h0000,0,8'h00));
    vecs.push_back(v(1,0,8'h02,3,0,0,16'h0001,16'h0000, 1,0,2,16'h0001,1,0,0,0,16'h0000,0,8'h00));
    vecs.push_back(v(1,0,8'h02,3,0,0,16'h0002,16'h0000, 1,1,2,16'h0002,1,0,0,0,16'h0000,0,8'h00));
    vecs.push_back(v(1,0,8'h02,3,0,0,16'h0003,16'h0000, 1,2,2,16'h0003,1,0,0,0,16'h0000,0,8'h00));
    vecs.push_back(v(1,0,8'h02,3,0,0,16'h0004,16'h0000, 1,3,2,16'h0004,1,0,0,0,16'h0000,0,8'h00));
    vecs.push_back(v(1,0,8'h02,3,0,0,16'h0005,16'h0000, 0,3,2,16'h0004,1,0,0,0,16'h0000,0,8'h02));
    vecs.push_back(v(0,0,8'h02,3,0,0,16'h0000,16'h0000, 0,3,2,16'h0004,1,0,0,0,16'h0000,0,8'h02));
    // Commit; busy frame is skipped, idle frame swaps.
    vecs.push_back(v(0,0,8'h42,3,0,0,16'h0000,16'h0000, 0,3,2,16'h0004,1,0,0,0,16'h0000,1,8'h02));
    vecs.push_back(v(0,0,8'h42,3,1,1,16'h0000,16'h0000, 0,3,2,16'h0004,1,0,0,0,16'h0000,1,8'h02));
    vecs.push_back(v(0,0,8'h42,3,0,0,16'h0000,16'h0000, 0,3,2,16'h0004,1,0,0,0,16'h0000,1,8'h02));
    vecs.push_back(v(0,0,8'h42,3,1,0,16'h0000,16'h0000, 0,3,2,16'h0004,0,1,0,0,16'h0000,0,8'h03));
    // Write to new shadow bank 0, then a strobe while pending is rejected.
    vecs.push_back(v(1,0,8'h02,3,0,0,16'h0011,16'h0000, 1,0,2,16'h0011,0,1,0,0,16'h0000,0,8'h03));
    vecs.push_back(v(0,0,8'h42,3,0,0,16'h0000,16'h0000, 0,0,2,16'h0011,0,1,0,0,16'h0000,1,8'h02));
    vecs.push_back(v(1,0,8'h42,3,0,0,16'h00AA,16'h0000, 0,0,2,16'h0011,0,1,0,0,16'h0000,1,8'h06));
    vecs.push_back(v(0,0,8'h42,3,1,0,16'h0000,16'h0000, 0,0,2,16'h0011,1,0,0,0,16'h0000,0,8'h07));
    // Nine simultaneous coef + EQ writes; EQ address wraps 7 -> 0.
    for (int i = 0; i < 9; i++) begin
      vecs.push_back(v(1,1,8'h02,15,0,0,16'h0100 + 16'(i),16'h0E00 + 16'(i),
                       1,8'(i),2,16'h0100 + 16'(i),1,0,1,3'(i % 8),16'h0E00 + 16'(i),0,8'h07));
    end
    vecs.push_back(v(0,0,8'h02,15,0,0,16'h0000,16'h0000, 0,8,2,16'h0108,1,0,0,0,16'h0E08,0,8'h07));
    // Filter change clears counter; restart at count 2 writes addr 0 and clears status.
    vecs.push_back(v(1,0,8'h01,15,0,0,16'h0201,16'h0000, 1,0,1,16'h0201,1,0,0,0,16'h0E08,0,8'h07));
    vecs.push_back(v(1,0,8'h01,15,0,0,16'h0202,16'h0000, 1,1,1,16'h0202,1,0,0,0,16'h0E08,0,8'h07));
    vecs.push_back(v(1,0,8'h81,15,0,0,16'h0203,16'h0000, 1,0,1,16'h0203,1,0,0,0,16'h0E08,0,8'h00));
    vecs.push_back(v(1,1,8'h81,15,0,0,16'h0204,16'h0E55, 1,1,1,16'h0204,1,0,1,0,16'h0E55,0,8'h00));

    // Reset state.
    idle_inputs();
    filter_select = 8'h00; taps_per_filter = 8'd3; reset_n = 1'b0;
    tick(); tick();
    chk_quiet("reset");
    chk("reset.coef_addr", 32'(coef_addr), 32'd0);
    chk("reset.eq_addr", 32'(eq_addr), 32'd0);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      string t;
      t = $sformatf("vec%0d", i);
      coef_wr_stb = vecs[i].c; eq_wr_stb = vecs[i].e; filter_select = vecs[i].fsel;
      taps_per_filter = vecs[i].taps; frame_stb = vecs[i].frm; fir_busy = vecs[i].bsy;
      {coef_msb, coef_lsb} = vecs[i].cd; {eq_msb, eq_lsb} = vecs[i].ed;
      tick();
      chk({t, ".coef_we"}, 32'(coef_we), 32'(vecs[i].we));
      chk({t, ".coef_addr"}, 32'(coef_addr), 32'(vecs[i].addr));
      chk({t, ".coef_filter"}, 32'(coef_filter), 32'(vecs[i].filt));
      chk({t, ".coef_wdata"}, 32'(coef_wdata), 32'(vecs[i].wd));
      chk({t, ".coef_bank"}, 32'(coef_bank), 32'(vecs[i].cb));
      chk({t, ".active_bank"}, 32'(active_bank), 32'(vecs[i].ab));
      chk({t, ".eq_we"}, 32'(eq_we), 32'(vecs[i].eqwe));
      chk({t, ".eq_addr"}, 32'(eq_addr), 32'(vecs[i].eqa));
      chk({t, ".eq_wdata"}, 32'(eq_wdata), 32'(vecs[i].eqwd));
      chk({t, ".load_busy"}, 32'(load_busy), 32'(vecs[i].lb));
      chk({t, ".status"}, 32'(status), 32'(vecs[i].st));
    end

    // Reset while a commit is pending abandons the swap.
    idle_inputs();
    filter_select = 8'h41;
    tick();
    chk("pend.load_busy", 32'(load_busy), 32'd1);
    reset_n = 1'b0; filter_select = 8'h01;
    tick();
    reset_n = 1'b1; frame_stb = 1'b1; fir_busy = 1'b0;
    tick();
    chk_quiet("post_reset_frame1");
    tick();
    chk_quiet("post_reset_frame2");
    idle_inputs();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/coef_load_sequencer.md
Name: coef_load_sequencer

Overview:
Controller between spi_Interface and the AudioProcessing FIR/EQ coefficient memories. It turns single-cycle SPI write strobes into addressed coefficient/EQ RAM writes with auto-incrementing addresses. FIR coefficients are double-buffered: the CPU loads the shadow bank, then a commit swaps banks on a sample-frame boundary while the FIR MAC is idle, so the datapath never reads a half-loaded filter set.

Parameters:
NUM_FILTERS, 4, number of FIR filters (filter index width = 2)
ADDR_W, 8, coefficient address width per filter (max 256 taps)
COEF_W, 16, coefficient/EQ gain data width
NUM_EQ, 8, number of equalizer gain words

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
coef_wr_stb  in  1  one-cycle strobe, FIR coefficient write from SPI
eq_wr_stb  in  1  one-cycle strobe, EQ gain write from SPI
filter_select  in  8  [1:0] target filter; [6] commit request (rising edge); [7] address restart (rising edge)
taps_per_filter  in  8  taps per filter minus 1
coef_lsb, coef_msb  in  8 each  coefficient data bytes
eq_lsb, eq_msb  in  8 each  EQ gain data bytes
frame_stb  in  1  one-cycle pulse at each stereo frame start (from audio datapath)
fir_busy  in  1  high while the FIR MAC reads coefficients
coef_we  out  1  coefficient RAM write enable
coef_bank  out  1  bank being written (always ~active_bank)
coef_filter  out  2  filter index of write
coef_addr  out  ADDR_W  tap address of write
coef_wdata  out  COEF_W  {coef_msb, coef_lsb}
active_bank  out  1  bank the FIR datapath reads
eq_we  out  1  EQ RAM write enable
eq_addr  out  3  EQ word address
eq_wdata  out  COEF_W  {eq_msb, eq_lsb}
load_busy  out  1  commit pending
status  out  8  [0] commit done (sticky), [1] overflow error (sticky), [2] write-while-pending error (sticky), [7:3] 0

Behaviour:
- Reset (reset_n low at a clk edge): all outputs 0, active_bank=0, coef_bank=1, address counters 0, state IDLE, edge-detect history cleared. A reset during PEND_SWAP abandons the commit; the bank is not swapped.
- States: IDLE, PEND_SWAP.
- IDLE, coef_wr_stb:
  - Next cycle coef_we=1 for exactly one cycle, with coef_filter=filter_select[1:0], coef_addr=counter, coef_wdata registered from the strobe cycle.
  - Counter then increments.
  - If counter > taps_per_filter at the strobe: write suppressed (coef_we stays 0), status[1] set, counter holds.
- A change of filter_select[1:0] (compared with the previous cycle) clears the coefficient counter.
- Rising edge of filter_select[7] clears both the coefficient and EQ counters. If a strobe arrives in the same cycle, the restart applies first: the write lands at address 0 and the counter becomes 1.
- Rising edge of filter_select[6] in IDLE: enter PEND_SWAP, load_busy=1, clear status[0].
- PEND_SWAP:
  - Swap on the first cycle with frame_stb=1 and fir_busy=0: toggle active_bank and coef_bank, clear coefficient counter, set status[0], load_busy=0, return to IDLE.
  - frame_stb while fir_busy=1: wait for the next frame_stb.
  - coef_wr_stb in PEND_SWAP: ignored, status[2] set.
  - A second commit edge in PEND_SWAP: ignored.
- EQ path, independent of state:
  - eq_wr_stb → next cycle eq_we=1 for one cycle, with eq_addr=counter, data registered.
  - Counter wraps NUM_EQ-1→0.
  - EQ is not double-buffered.
- coef_wr_stb and eq_wr_stb in the same cycle: both serviced in parallel.
- Sticky status bits clear only on reset or on the restart edge. Exception: status[0] also clears on a new commit edge.
- Write latency is fixed at 1 cycle from strobe to we. Strobes on back-to-back cycles produce back-to-back writes.

Test Plan:
- Reset, taps_per_filter=3, filter 2, four coef_wr_stb with data 0x0001..0x0004 → four coef_we pulses, addr 0..3, filter 2, bank 1, each 1 cycle after its strobe; a fifth strobe → no coef_we, status[1]=1.
- Commit edge, then frame_stb with fir_busy=1, then frame_stb with fir_busy=0 → active_bank 0→1 on the second pulse only, coef_bank=0, status[0]=1, load_busy low afterwards.
- coef_wr_stb during PEND_SWAP → no coef_we, status[2]=1, counter unchanged.
- Nine eq_wr_stb issued simultaneously with coef_wr_stb → eq_addr 0..7 then 0; coef writes are unaffected and occur in the same cycles.
- Restart edge coincident with coef_wr_stb when the counter is at 2 → write at addr 0, the next write at addr 1, status[1:2] cleared.
- Assert reset_n=0 mid-PEND_SWAP, then frame_stb → active_bank stays 0, load_busy=0, all we=0.
